// File: rtl/down_timer_pkg.sv
// Shared types and constants for the programmable down-counter/timer.
package down_timer_pkg;

  // Controller state; busy is simply "state is RUN".
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Expire behaviour selected by the mode input.
  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/down_timer_if.sv
// Control/status bundle between a timer client (master) and the timer (slave).
interface down_timer_if #(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 8
);
  logic               ena;
  logic               start;
  logic               stop;
  logic               load;
  logic [WIDTH-1:0]   load_val;
  logic               mode;
  logic [PRESC_W-1:0] presc_div;
  logic               clr;
  logic [WIDTH-1:0]   cnt;
  logic               tc;
  logic               busy;
  logic               done;

  modport master (
    output ena, start, stop, load, load_val, mode, presc_div, clr,
    input  cnt, tc, busy, done
  );

  modport slave (
    input  ena, start, stop, load, load_val, mode, presc_div, clr,
    output cnt, tc, busy, done
  );
endinterface

// File: rtl/timer_prescaler.sv
// Clock-enable divider: one tick every presc_div+1 enabled cycles.
module timer_prescaler #(
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run_en,
  input  logic               sync_clr,
  input  logic [PRESC_W-1:0] presc_div,
  output logic               tick
);

  localparam logic [PRESC_W-1:0] ONE = PRESC_W'(1);

  logic [PRESC_W-1:0] r_presc_cnt;

  assign tick = run_en && (r_presc_cnt == presc_div);

  // Phase counter: restarts on sync_clr or tick, advances only while enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_presc_cnt <= '0;
    else if (sync_clr) r_presc_cnt <= '0;
    else if (tick)     r_presc_cnt <= '0;
    else if (run_en)   r_presc_cnt <= r_presc_cnt + ONE;
  end

endmodule

// File: rtl/down_timer.sv
// Programmable down-counter/timer: reload register, one-shot/periodic,
// prescaled tick, start/stop control, registered tc pulse, sticky done.
module down_timer
  import down_timer_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               PRESC_W   = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic      clk,
  input  logic      rst_n,
  down_timer_if.slave s_if
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           r_state, w_state_nxt;
  logic             r_busy;
  logic [WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_reload, w_reload_nxt;
  logic             r_tc;
  logic             r_done;

  logic w_start_eff;
  logic w_evt;
  logic w_run_en;
  logic w_sync_clr;
  logic w_tick;
  logic w_expire;

  // stop overrides start; any control pulse steals that cycle's tick.
  assign w_start_eff = s_if.start & ~s_if.stop;
  assign w_evt       = s_if.start | s_if.stop | s_if.load;
  assign w_run_en    = (r_state == ST_RUN) & s_if.ena & ~w_evt;
  assign w_sync_clr  = s_if.load | w_start_eff;
  assign w_expire    = w_tick & (r_cnt == '0);

  timer_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .clk       (clk),
    .rst_n     (rst_n),
    .run_en    (w_run_en),
    .sync_clr  (w_sync_clr),
    .presc_div (s_if.presc_div),
    .tick      (w_tick)
  );

  // State register; busy flop tracks the next state so it equals (state==RUN).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == ST_RUN);
    end
  end

  // Next-state: stop wins everywhere, start (re)enters RUN, one-shot expire parks in DONE.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_start_eff) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (s_if.stop)                                 w_state_nxt = ST_IDLE;
        else if (w_expire && s_if.mode == MODE_ONESHOT) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (s_if.stop)        w_state_nxt = ST_IDLE;
        else if (s_if.start)  w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Counter/reload next values: load > start > expire reload > tick decrement.
  always_comb begin
    w_cnt_nxt    = r_cnt;
    w_reload_nxt = r_reload;
    if (s_if.load) begin
      w_reload_nxt = s_if.load_val;
      w_cnt_nxt    = s_if.load_val;
    end else if (w_start_eff) begin
      w_cnt_nxt = r_reload;
    end else if (w_expire) begin
      if (s_if.mode == MODE_PERIODIC) w_cnt_nxt = r_reload;
    end else if (w_tick) begin
      w_cnt_nxt = r_cnt - ONE;
    end
  end

  // Datapath registers; done is sticky with set taking priority over clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= RESET_VAL;
      r_reload <= RESET_VAL;
      r_tc     <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_reload <= w_reload_nxt;
      r_tc     <= w_expire;
      if (w_expire)       r_done <= 1'b1;
      else if (s_if.clr)  r_done <= 1'b0;
    end
  end

  assign s_if.cnt  = r_cnt;
  assign s_if.tc   = r_tc;
  assign s_if.busy = r_busy;
  assign s_if.done = r_done;

endmodule

// File: tb/tb_down_timer.sv
// Bench for down_timer: vector table, directed corner sequences, random run vs model.
module tb_down_timer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  down_timer_if #(.WIDTH(8), .PRESC_W(8)) ifc();

  down_timer #(.WIDTH(8), .PRESC_W(8), .RESET_VAL(8'hFF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s_if  (ifc)
  );

  int n_run  = 0;
  int n_fail = 0;

  // Reference model state (0=idle, 1=running, 2=finished one-shot).
  logic [7:0] m_cnt, m_reload, m_presc;
  int         m_st;
  logic       m_tc, m_done;

  typedef struct packed {
    logic       ena, start, stop, load;
    logic [7:0] lv;
    logic       mode;
    logic [7:0] pd;
    logic       clr;
    logic [7:0] e_cnt;
    logic       e_tc, e_busy, e_done;
  } vec_t;

  vec_t tv [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic mreset();
    m_cnt = 8'hFF; m_reload = 8'hFF; m_presc = 8'h00;
    m_st = 0; m_tc = 1'b0; m_done = 1'b0;
  endtask

  // One clock of the timer rules, using the inputs present at the edge.
  task automatic mstep();
    logic strt, run, tk, ex;
    strt = ifc.start && !ifc.stop;
    run  = (m_st == 1) && ifc.ena && !(ifc.start || ifc.stop || ifc.load);
    tk   = run && (m_presc == ifc.presc_div);
    ex   = tk && (m_cnt == 8'd0);
    m_tc = ex;
    if (ex) m_done = 1'b1; else if (ifc.clr) m_done = 1'b0;
    if (ifc.load || strt || tk) m_presc = 8'd0;
    else if (run)               m_presc = m_presc + 8'd1;
    if (ifc.load) begin m_reload = ifc.load_val; m_cnt = ifc.load_val; end
    else if (strt)             m_cnt = m_reload;
    else if (ex && ifc.mode)   m_cnt = m_reload;
    else if (tk && !ex)        m_cnt = m_cnt - 8'd1;
    if (ifc.stop)            m_st = 0;
    else if (ifc.start)      m_st = 1;
    else if (ex && !ifc.mode) m_st = 2;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".cnt"},  ifc.cnt,  m_cnt);
    chk({tag, ".tc"},   ifc.tc,   m_tc);
    chk({tag, ".busy"}, ifc.busy, (m_st == 1));
    chk({tag, ".done"}, ifc.done, m_done);
  endtask

  task automatic cyc();
    @(posedge clk);
    mstep();
    #1;
    chk_model("mdl");
  endtask

  task automatic pulses_off();
    ifc.start = 1'b0; ifc.stop = 1'b0; ifc.load = 1'b0; ifc.clr = 1'b0;
  endtask

  task automatic load_start(input logic [7:0] lv, input logic md, input logic [7:0] pd);
    ifc.load = 1'b1; ifc.start = 1'b1; ifc.load_val = lv; ifc.mode = md; ifc.presc_div = pd;
    cyc();
    pulses_off();
  endtask

  function automatic vec_t mk(input logic st, input logic sp, input logic ld, input logic [7:0] lv,
                              input logic cl, input logic [7:0] c, input logic t, input logic b,
                              input logic d);
    vec_t v;
    v.ena = 1'b1; v.start = st; v.stop = sp; v.load = ld; v.lv = lv; v.mode = 1'b0;
    v.pd = 8'd0; v.clr = cl; v.e_cnt = c; v.e_tc = t; v.e_busy = b; v.e_done = d;
    return v;
  endfunction

  initial begin
    // One-shot, reload=5, no prescale: 5,4,3,2,1,0 then expire on the 6th tick.
    tv[0] = mk(0, 0, 1, 8'd5, 0, 8'd5, 0, 0, 0);
    tv[1] = mk(1, 0, 0, 8'd0, 0, 8'd5, 0, 1, 0);
    tv[2] = mk(0, 0, 0, 8'd0, 0, 8'd4, 0, 1, 0);
    tv[3] = mk(0, 0, 0, 8'd0, 0, 8'd3, 0, 1, 0);
    tv[4] = mk(0, 0, 0, 8'd0, 0, 8'd2, 0, 1, 0);
    tv[5] = mk(0, 0, 0, 8'd0, 0, 8'd1, 0, 1, 0);
    tv[6] = mk(0, 0, 0, 8'd0, 0, 8'd0, 0, 1, 0);
    tv[7] = mk(0, 0, 0, 8'd0, 0, 8'd0, 1, 0, 1);
    tv[8] = mk(0, 0, 0, 8'd0, 0, 8'd0, 0, 0, 1);
    tv[9] = mk(0, 0, 0, 8'd0, 1, 8'd0, 0, 0, 0);

    rst_n = 1'b0;
    ifc.ena = 1'b1; ifc.load_val = 8'd0; ifc.mode = 1'b0; ifc.presc_div = 8'd0;
    pulses_off();
    mreset();
    #12;
    chk("rst.cnt", ifc.cnt, 8'hFF);
    chk("rst.tc", ifc.tc, 1'b0);
    chk("rst.busy", ifc.busy, 1'b0);
    chk("rst.done", ifc.done, 1'b0);
    rst_n = 1'b1;

    // Vector table
    for (int i = 0; i < 10; i++) begin
      ifc.ena = tv[i].ena; ifc.start = tv[i].start; ifc.stop = tv[i].stop; ifc.load = tv[i].load;
      ifc.load_val = tv[i].lv; ifc.mode = tv[i].mode; ifc.presc_div = tv[i].pd; ifc.clr = tv[i].clr;
      cyc();
      chk($sformatf("vec%0d.cnt", i), ifc.cnt, tv[i].e_cnt);
      chk($sformatf("vec%0d.tc", i), ifc.tc, tv[i].e_tc);
      chk($sformatf("vec%0d.busy", i), ifc.busy, tv[i].e_busy);
      chk($sformatf("vec%0d.done", i), ifc.done, tv[i].e_done);
    end
    pulses_off();

    // Periodic reload=3, presc_div=2: tc every 12 cycles; clr on expire edge loses to set.
    load_start(8'd3, 1'b1, 8'd2);
    for (int k = 1; k <= 36; k++) begin
      ifc.clr = (k == 24);
      cyc();
      chk($sformatf("per.tc%0d", k), ifc.tc, (k % 12 == 0));
      if (k % 12 == 0) chk("per.reload", ifc.cnt, 8'd3);
      if (k == 24) chk("per.clr_vs_set", ifc.done, 1'b1);
    end
    ifc.clr = 1'b1; cyc(); ifc.clr = 1'b0;
    chk("per.clr", ifc.done, 1'b0);
    ifc.stop = 1'b1; cyc(); pulses_off();
    chk("per.stop", ifc.busy, 1'b0);

    // ena low for 4 cycles: expire slips from cycle 12 to cycle 16.
    load_start(8'd5, 1'b0, 8'd1);
    for (int k = 1; k <= 17; k++) begin
      ifc.ena = !(k >= 3 && k <= 6);
      cyc();
      chk($sformatf("ena.tc%0d", k), ifc.tc, (k == 16));
      if (k == 6) chk("ena.frozen", ifc.cnt, 8'd4);
    end
    ifc.ena = 1'b1;

    // stop at cnt=2 holds the value; restart; stop+start together goes idle.
    load_start(8'd5, 1'b0, 8'd0);
    cyc(); cyc(); cyc();
    chk("stop.pre", ifc.cnt, 8'd2);
    ifc.stop = 1'b1; cyc(); pulses_off();
    chk("stop.cnt", ifc.cnt, 8'd2);
    chk("stop.busy", ifc.busy, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("stop.hold", ifc.cnt, 8'd2);
      chk("stop.notc", ifc.tc, 1'b0);
    end
    ifc.start = 1'b1; cyc(); pulses_off();
    chk("restart.cnt", ifc.cnt, 8'd5);
    chk("restart.busy", ifc.busy, 1'b1);
    cyc();
    chk("restart.dec", ifc.cnt, 8'd4);
    ifc.stop = 1'b1; ifc.start = 1'b1; cyc(); pulses_off();
    chk("stopstart.busy", ifc.busy, 1'b0);
    chk("stopstart.cnt", ifc.cnt, 8'd4);

    // load during RUN at cnt=3: cnt=7 with no decrement, period restarts.
    ifc.start = 1'b1; cyc(); pulses_off();
    cyc(); cyc();
    chk("ldrun.pre", ifc.cnt, 8'd3);
    ifc.load = 1'b1; ifc.load_val = 8'd7; cyc(); pulses_off();
    chk("ldrun.cnt", ifc.cnt, 8'd7);
    chk("ldrun.busy", ifc.busy, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      cyc();
      chk($sformatf("ldrun.tc%0d", k), ifc.tc, (k == 8));
    end

    // Continuous tc (periodic, reload=0), then async reset between edges.
    load_start(8'd0, 1'b1, 8'd0);
    cyc(); cyc();
    chk("cont.tc", ifc.tc, 1'b1);
    chk("cont.done", ifc.done, 1'b1);
    #3;
    rst_n = 1'b0;
    mreset();
    #1;
    chk("arst.cnt", ifc.cnt, 8'hFF);
    chk("arst.tc", ifc.tc, 1'b0);
    chk("arst.busy", ifc.busy, 1'b0);
    chk("arst.done", ifc.done, 1'b0);
    ifc.mode = 1'b0;
    @(posedge clk);
    #3;
    chk("arst.hold_tc", ifc.tc, 1'b0);
    rst_n = 1'b1;
    ifc.start = 1'b1; cyc(); pulses_off();
    chk("arst.start", ifc.cnt, 8'hFF);
    cyc();
    chk("arst.dec", ifc.cnt, 8'hFE);

    // Random control traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      ifc.ena      = ($urandom_range(0, 9) != 0);
      ifc.start    = ($urandom_range(0, 29) == 0);
      ifc.stop     = ($urandom_range(0, 59) == 0);
      ifc.load     = ($urandom_range(0, 39) == 0);
      ifc.load_val = 8'($urandom_range(0, 12));
      ifc.clr      = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 49) == 0) ifc.mode = ~ifc.mode;
      if ($urandom_range(0, 199) == 0) ifc.presc_div = 8'($urandom_range(0, 3));
      cyc();
    end
    pulses_off();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
